pdm_sequencer: RTL and testbench

Playback controller for the 5-bit first-order PDM modulator. A short waveform is loaded into a local sample memory while the block is idle. The block then streams the samples into the modulator's input register (sample bus plus write strobe) at a programmable interval, either once or in a loop. It sits between the chip-level IO and the PDM core and is the only writer of the core's input register.

---
 rtl/pdm_sequencer.sv | 145 ++++++++++++++
 tb/tb_pdm_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_sequencer.sv
// Playback controller: loads a short waveform while idle and streams it into the PDM core input register.
// Optional PDM_SEQ_HOLD_EN adds a hold input that pauses playback in place.
module pdm_sequencer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 5,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic [DIV_W-1:0] rate,
`ifdef PDM_SEQ_HOLD_EN
    input  logic             hold,
`endif
    output logic [WIDTH-1:0] pdm_sample,
    output logic             pdm_we,
    output logic             busy,
    output logic             full,
    output logic             seq_done,
    output logic [1:0]       state_dbg
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    length;
    logic [PW-1:0]    rd_ptr;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] rate_q;
    logic             loop_q;
    logic             load_ok;
    logic             start_ok;
    logic             hold_act;
    logic             last_entry;

    // Handshake: wr_en/clear/start are single-cycle strobes honoured only in IDLE;
    // pdm_we is a one-cycle write pulse with pdm_sample valid in the same cycle.
    assign load_ok    = (state == IDLE) && wr_en && !clear && !full;
    assign start_ok   = (state == IDLE) && start && !wr_en && !clear && (length != '0);
    assign last_entry = (LW'(rd_ptr) == (length - LW'(1)));
    assign state_dbg  = state;

`ifdef PDM_SEQ_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    // Sample memory is deliberately left out of reset; length gates visibility.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[length[PW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            length     <= '0;
            rd_ptr     <= '0;
            div        <= '0;
            rate_q     <= '0;
            loop_q     <= 1'b0;
            pdm_sample <= '0;
            pdm_we     <= 1'b0;
            busy       <= 1'b0;
            full       <= 1'b0;
            seq_done   <= 1'b0;
        end else begin
            pdm_we   <= 1'b0;
            seq_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        length <= '0;
                        full   <= 1'b0;
                    end else if (load_ok) begin
                        length <= length + LW'(1);
                        full   <= (length == LW'(DEPTH - 1));
                    end else if (start_ok) begin
                        state      <= PLAY;
                        busy       <= 1'b1;
                        rate_q     <= rate;
                        loop_q     <= loop;
                        rd_ptr     <= '0;
                        div        <= '0;
                        pdm_we     <= 1'b1;
                        pdm_sample <= mem[0];
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state      <= FLUSH;
                        pdm_we     <= 1'b1;
                        pdm_sample <= '0;
                        seq_done   <= 1'b1;
                    end else if (!hold_act) begin
                        if (div != rate_q) begin
                            div <= div + DIV_W'(1);
                        end else begin
                            div <= '0;
                            // rd_ptr tracks the entry most recently written to the core
                            if (!last_entry) begin
                                rd_ptr     <= rd_ptr + PW'(1);
                                pdm_we     <= 1'b1;
                                pdm_sample <= mem[rd_ptr + PW'(1)];
                            end else if (loop_q) begin
                                rd_ptr     <= '0;
                                pdm_we     <= 1'b1;
                                pdm_sample <= mem[0];
                            end else begin
                                state      <= FLUSH;
                                pdm_we     <= 1'b1;
                                pdm_sample <= '0;
                                seq_done   <= 1'b1;
                            end
                        end
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_sequencer.sv
// Bench for pdm_sequencer: directed and randomized playback checked against a slot-arithmetic model.
module tb_pdm_sequencer;

    localparam int DEPTH = 8;
    localparam int WIDTH = 5;
    localparam int DIV_W = 4;

    logic             clk;
    logic             reset_n;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             clear;
    logic             start;
    logic             stop;
    logic             loop;
    logic [DIV_W-1:0] rate;
    logic [WIDTH-1:0] pdm_sample;
    logic             pdm_we;
    logic             busy;
    logic             full;
    logic             seq_done;
    logic [1:0]       state_dbg;

    // Reference contents of the sample memory, in load order.
    logic [WIDTH-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    pdm_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
        .clear(clear), .start(start), .stop(stop), .loop(loop), .rate(rate),
        .pdm_sample(pdm_sample), .pdm_we(pdm_we), .busy(busy), .full(full),
        .seq_done(seq_done), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        chk("full", {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        chk("full_clr", {31'd0, full}, 32'd0);
    endtask

    // Writes fall at offsets 1 + n*(r+1) after start; stop during cycle S flushes at S+1.
    task automatic play(input int r, input bit lp, input int stop_t, input bit noise);
        int len;
        int n;
        int budget;
        logic [WIDTH-1:0] held;
        bit done;
        bit e_we;
        bit e_done;
        len = exp_q.size();
        done = 1'b0;
        held = '0;
        rate = DIV_W'(r);
        loop = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
        budget = (lp ? stop_t : len * (r + 1)) + 4;
        for (int t = 1; t <= budget && !done; t++) begin
            e_we = 1'b0;
            e_done = 1'b0;
            if (stop_t > 0 && t == stop_t + 1) begin
                e_we = 1'b1; held = '0; e_done = 1'b1; done = 1'b1;
            end else if ((t - 1) % (r + 1) == 0) begin
                n = (t - 1) / (r + 1);
                e_we = 1'b1;
                if (n < len || lp) begin
                    held = exp_q[n % len];
                end else begin
                    held = '0; e_done = 1'b1; done = 1'b1;
                end
            end
            chk("pdm_we", {31'd0, pdm_we}, {31'd0, e_we});
            chk("pdm_sample", {27'd0, pdm_sample}, {27'd0, held});
            chk("seq_done", {31'd0, seq_done}, {31'd0, e_done});
            chk("busy", {31'd0, busy}, 32'd1);
            if (!done && t == stop_t) stop = 1'b1;
            if (noise) begin
                wr_en = 1'($urandom_range(0, 1));
                clear = 1'($urandom_range(0, 1));
                wr_data = WIDTH'($urandom_range(0, 31));
            end
            tick();
            stop = 1'b0;
            wr_en = 1'b0;
            clear = 1'b0;
        end
        chk("play_end", {31'd0, done}, 32'd1);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("we_after", {31'd0, pdm_we}, 32'd0);
        chk("done_after", {31'd0, seq_done}, 32'd0);
    endtask

    initial begin
        int len;
        int r;
        bit lp;
        int st;
        logic [WIDTH-1:0] d;
        n_checks = 0;
        n_fail = 0;
        reset_n = 1'b0;
        wr_en = 1'b0; wr_data = '0; clear = 1'b0; start = 1'b0;
        stop = 1'b0; loop = 1'b0; rate = '0;
        tick();
        tick();
        chk("rst_we", {31'd0, pdm_we}, 32'd0);
        chk("rst_sample", {27'd0, pdm_sample}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_done", {31'd0, seq_done}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Three-sample one-shot at rate 2
        load(5'h04); load(5'h10); load(5'h1F);
        play(2, 1'b0, 0, 1'b0);

        // Fill memory, overflow write dropped, back-to-back loop
        do_clear();
        for (int i = 0; i < DEPTH; i++) load(WIDTH'($urandom_range(1, 31)));
        load(WIDTH'($urandom_range(0, 31)));
        play(0, 1'b1, 10, 1'b0);

        // Stop one cycle before a scheduled write pre-empts it
        play(3, 1'b1, 8, 1'b0);

        // Start with empty memory is ignored
        do_clear();
        start = 1'b1; tick(); start = 1'b0;
        chk("empty_busy", {31'd0, busy}, 32'd0);
        chk("empty_we", {31'd0, pdm_we}, 32'd0);
        tick();
        chk("empty_busy2", {31'd0, busy}, 32'd0);
        chk("empty_we2", {31'd0, pdm_we}, 32'd0);

        // Clear wins over a same-cycle load
        load(5'h0A);
        clear = 1'b1; wr_en = 1'b1; wr_data = 5'h07;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        exp_q.delete();
        chk("clr_wr_full", {31'd0, full}, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("clr_wr_busy", {31'd0, busy}, 32'd0);

        // Start together with wr_en: load happens, start ignored
        for (int i = 0; i < 3; i++) load(WIDTH'($urandom_range(0, 31)));
        d = WIDTH'($urandom_range(0, 31));
        wr_en = 1'b1; wr_data = d; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        exp_q.push_back(d);
        chk("st_wr_busy", {31'd0, busy}, 32'd0);
        chk("st_wr_we", {31'd0, pdm_we}, 32'd0);

        // Loads and clears during playback must not disturb memory
        play(1, 1'b0, 0, 1'b1);
        play(0, 1'b0, 0, 1'b0);

        // Randomized programs
        for (int k = 0; k < 8; k++) begin
            do_clear();
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) load(WIDTH'($urandom_range(0, 31)));
            r = $urandom_range(0, 3);
            lp = 1'($urandom_range(0, 1));
            st = lp ? $urandom_range(1, 2 * len * (r + 1)) : $urandom_range(0, len * (r + 1) + 2);
            play(r, lp, st, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of playback
        do_clear();
        load(5'h11); load(5'h15);
        rate = '0; loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_we", {31'd0, pdm_we}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_we", {31'd0, pdm_we}, 32'd0);
        chk("arst_sample", {27'd0, pdm_sample}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_we", {31'd0, pdm_we}, 32'd0);
        tick();
        chk("post_rst_we2", {31'd0, pdm_we}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
